vga_pixel_arbiter: RTL and testbench

Merges pixel-write requests from several drawing datapaths (laser towers, car sprites, background restorers) into the single pixel port of the 160x120 VGA adapter. Each source gets a small FIFO with a valid/ready handshake. A round-robin arbiter drains the FIFOs at one pixel per clock. Off-screen pixels are clipped and counted. The block sits directly downstream of every tower/car datapath that produces `{x,y}` coordinates and a 9-bit colour.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/pixel_fifo.sv | 59 +++++
 rtl/vga_pixel_arbiter.sv | 138 +++++++++++++
 tb/tb_vga_pixel_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared screen geometry, pixel payload and clip test for the VGA pixel arbiter.
package vga_pkg;

    localparam int unsigned VGA_W    = 160;
    localparam int unsigned VGA_H    = 120;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 9;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    // High when the pixel lies outside the visible 160x120 area.
    function automatic logic clip(input pixel_t p);
        return (p.x >= X_W'(VGA_W)) || (p.y >= Y_W'(VGA_H));
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Per-source pixel FIFO: registered count, wrapping pointers, no bypass.
module pixel_fifo
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = pixel_t,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  T              din,
    output T              dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/vga_pixel_arbiter.sv
// Round-robin merge of per-source pixel FIFOs onto the single VGA adapter port.
module vga_pixel_arbiter #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned X_W        = vga_pkg::X_W,
    parameter int unsigned Y_W        = vga_pkg::Y_W,
    parameter int unsigned COLOUR_W   = vga_pkg::COLOUR_W,
    localparam int unsigned SW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*(X_W+Y_W)-1:0]  src_coords,
    input  logic [NUM_SRC*COLOUR_W-1:0]   src_colour,
    output logic [X_W-1:0]                vga_x,
    output logic [Y_W-1:0]                vga_y,
    output logic [COLOUR_W-1:0]           vga_colour,
    output logic                          vga_plot,
    output logic [SW-1:0]                 vga_grant_src,
    output logic [7:0]                    clip_count,
    output logic                          busy
);
    import vga_pkg::*;

    localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned XY_W = X_W + Y_W;

    pixel_t               fifo_din  [NUM_SRC];
    pixel_t               fifo_dout [NUM_SRC];
    logic [CW-1:0]        fifo_count[NUM_SRC];
    logic [NUM_SRC-1:0]   fifo_full, fifo_empty, fifo_push, fifo_pop;

    logic [SW-1:0]        rr_last_q, rr_last_d;
    logic [SW-1:0]        grant_idx;
    logic                 grant_valid;
    pixel_t               head;
    logic                 head_clip;

    logic [X_W-1:0]       vga_x_q, vga_x_d;
    logic [Y_W-1:0]       vga_y_q, vga_y_d;
    logic [COLOUR_W-1:0]  vga_colour_q, vga_colour_d;
    logic [SW-1:0]        grant_src_q, grant_src_d;
    logic                 plot_q, plot_d;
    logic [7:0]           clip_count_q, clip_count_d;
    logic                 busy_q, busy_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign fifo_din[i]  = {src_coords[i*XY_W +: XY_W], src_colour[i*COLOUR_W +: COLOUR_W]};
        assign src_ready[i] = (fifo_count[i] != CW'(FIFO_DEPTH));
        assign fifo_push[i] = src_valid[i] & ~fifo_full[i];
        assign fifo_pop[i]  = grant_valid && (grant_idx == SW'(i));

        pixel_fifo #(
            .DEPTH (FIFO_DEPTH),
            .T     (pixel_t)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (fifo_push[i]),
            .pop   (fifo_pop[i]),
            .din   (fifo_din[i]),
            .dout  (fifo_dout[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i]),
            .count (fifo_count[i])
        );
    end

    // First non-empty FIFO scanning upward from the one after the last grant.
    always_comb begin
        logic [SW-1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = rr_last_q;
        cand        = '0;
        for (int k = 1; k <= int'(NUM_SRC); k++) begin
            cand = SW'((int'(rr_last_q) + k) % int'(NUM_SRC));
            if (!grant_valid && !fifo_empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign head      = fifo_dout[grant_idx];
    assign head_clip = clip(head);

    always_comb begin
        rr_last_d    = grant_valid ? grant_idx : rr_last_q;
        plot_d       = grant_valid && !head_clip;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        grant_src_d  = grant_src_q;
        clip_count_d = clip_count_q;
        busy_d       = (~&fifo_empty) | plot_q;
        if (plot_d) begin
            vga_x_d      = head.x;
            vga_y_d      = head.y;
            vga_colour_d = head.colour;
            grant_src_d  = grant_idx;
        end
        if (grant_valid && head_clip && (clip_count_q != 8'hFF)) begin
            clip_count_d = clip_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last_q    <= SW'(NUM_SRC - 1);
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            grant_src_q  <= '0;
            plot_q       <= 1'b0;
            clip_count_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            rr_last_q    <= rr_last_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            grant_src_q  <= grant_src_d;
            plot_q       <= plot_d;
            clip_count_q <= clip_count_d;
            busy_q       <= busy_d;
        end
    end

    assign vga_x         = vga_x_q;
    assign vga_y         = vga_y_q;
    assign vga_colour    = vga_colour_q;
    assign vga_plot      = plot_q;
    assign vga_grant_src = grant_src_q;
    assign clip_count    = clip_count_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_vga_pixel_arbiter.sv
// Directed bench for vga_pixel_arbiter with a per-source order scoreboard.
module tb_vga_pixel_arbiter;

    localparam int unsigned NS = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready;
    logic [NS*15-1:0]  src_coords;
    logic [NS*9-1:0]   src_colour;
    logic [7:0]        vga_x;
    logic [6:0]        vga_y;
    logic [8:0]        vga_colour;
    logic              vga_plot;
    logic [1:0]        vga_grant_src;
    logic [7:0]        clip_count;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit sb_en   = 1'b0;
    logic [25:0] exp_q[$];
    int plot_cnt [NS];

    vga_pixel_arbiter u_dut (
        .clk           (clk),
        .reset         (reset),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .src_coords    (src_coords),
        .src_colour    (src_colour),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_colour    (vga_colour),
        .vga_plot      (vga_plot),
        .vga_grant_src (vga_grant_src),
        .clip_count    (clip_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [7:0] x, input logic [6:0] y, input logic [8:0] c);
        src_coords[i*15 +: 15] = {x, y};
        src_colour[i*9 +: 9]   = c;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (busy && n < 64) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    // Record every accepted pixel while the scoreboard is armed.
    always @(posedge clk) begin
        if (sb_en && !reset) begin
            for (int i = 0; i < NS; i++) begin
                if (src_valid[i] && src_ready[i])
                    exp_q.push_back({2'(i), src_coords[i*15 +: 15], src_colour[i*9 +: 9]});
            end
        end
    end

    // Match each plot against the oldest outstanding pixel of that source.
    always @(posedge clk) begin : mon
        int found;
        #1;
        if (!reset && vga_plot) begin
            plot_cnt[vga_grant_src]++;
            if (sb_en) begin
                found = -1;
                for (int j = 0; j < exp_q.size(); j++)
                    if (found < 0 && exp_q[j][25:24] == vga_grant_src) found = j;
                if (found < 0) begin
                    chk("sb_extra_plot", 32'd1, 32'd0);
                end else begin
                    chk("sb_pixel", 32'({vga_x, vga_y, vga_colour}), 32'(exp_q[found][23:0]));
                    exp_q.delete(found);
                end
            end
        end
    end

    initial begin
        int acc, k, plots, base, guard;
        bit rdy, seen;
        logic [7:0] lx;
        logic [6:0] ly;
        logic [8:0] lc;

        for (int i = 0; i < NS; i++) plot_cnt[i] = 0;
        reset = 1'b1;
        src_valid = '0;
        src_coords = '0;
        src_colour = '0;
        tick();
        tick();
        chk("rst_plot",  32'(vga_plot), 32'd0);
        chk("rst_clip",  32'(clip_count), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_x",     32'(vga_x), 32'd0);
        chk("rst_grant", 32'(vga_grant_src), 32'd0);
        chk("rst_ready", 32'(src_ready), 32'hF);
        reset = 1'b0;
        tick();

        // Fairness: all sources valid, grants rotate 0..3 from source 0.
        sb_en = 1'b1;
        for (int i = 0; i < NS; i++) set_src(i, 8'(30 + i), 7'(40 + i), 9'(16 * i + 1));
        src_valid = 4'hF;
        tick();
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("fair_plot",  32'(vga_plot), 32'd1);
            chk("fair_grant", 32'(vga_grant_src), 32'(c % 4));
            chk("fair_x",     32'(vga_x), 32'(30 + c % 4));
            if (c == 6) src_valid = '0;
        end
        src_valid = '0;
        drain("fair_drain");
        chk("fair_sb_left", 32'(exp_q.size()), 32'd0);

        // Backpressure: source 0 fills while 1..3 keep streaming.
        base = plot_cnt[0];
        acc = 0;
        k = 0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            set_src(0, 8'd50, 7'(k), 9'(k + 1));
            for (int i = 1; i < NS; i++) set_src(i, 8'(60 + i), 7'(c), 9'(100 + c));
            src_valid = 4'hF;
            @(negedge clk);
            rdy = src_ready[0];
            if (!rdy && !seen) begin
                seen = 1'b1;
                chk("bp_occupancy", 32'(acc - (plot_cnt[0] - base)), 32'd4);
            end
            tick();
            if (rdy) begin
                acc++;
                k++;
            end
        end
        src_valid = '0;
        chk("bp_ready_dropped", 32'(seen), 32'd1);
        drain("bp_drain");
        tick();
        chk("bp_src0_all_out", 32'(plot_cnt[0] - base), 32'(acc));
        chk("bp_sb_left", 32'(exp_q.size()), 32'd0);

        // Single pixel on source 2: plot two edges after valid.
        set_src(2, 8'd10, 7'd20, 9'h1FF);
        src_valid = 4'b0100;
        tick();
        src_valid = '0;
        chk("one_lat1_plot", 32'(vga_plot), 32'd0);
        tick();
        chk("one_plot",   32'(vga_plot), 32'd1);
        chk("one_x",      32'(vga_x), 32'd10);
        chk("one_y",      32'(vga_y), 32'd20);
        chk("one_colour", 32'(vga_colour), 32'h1FF);
        chk("one_grant",  32'(vga_grant_src), 32'd2);
        chk("one_busy",   32'(busy), 32'd1);
        tick();
        chk("one_strobe", 32'(vga_plot), 32'd0);
        tick();
        chk("one_idle", 32'(busy), 32'd0);
        chk("one_sb_left", 32'(exp_q.size()), 32'd0);
        sb_en = 1'b0;

        // Clipping: two off-screen pixels dropped, the corner pixel plotted.
        plots = 0;
        lx = '0; ly = '0; lc = '0;
        src_valid = 4'b1000;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) set_src(3, 8'd160, 7'd5, 9'h011);
            if (c == 1) set_src(3, 8'd5, 7'd120, 9'h022);
            if (c == 2) set_src(3, 8'd159, 7'd119, 9'h0AB);
            if (c == 3) src_valid = '0;
            tick();
            if (vga_plot) begin
                plots++;
                lx = vga_x; ly = vga_y; lc = vga_colour;
            end
        end
        chk("clip_plots",  32'(plots), 32'd1);
        chk("clip_x",      32'(lx), 32'd159);
        chk("clip_y",      32'(ly), 32'd119);
        chk("clip_colour", 32'(lc), 32'h0AB);
        chk("clip_count",  32'(clip_count), 32'd2);

        // Saturation: 300 more off-screen pixels through source 1.
        acc = 0;
        plots = 0;
        guard = 0;
        set_src(1, 8'd200, 7'd0, 9'h000);
        while (acc < 300 && guard < 400) begin
            src_valid = 4'b0010;
            @(negedge clk);
            rdy = src_ready[1];
            tick();
            if (rdy) acc++;
            if (vga_plot) plots++;
            guard++;
        end
        src_valid = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (vga_plot) plots++;
        end
        chk("sat_accepted", 32'(acc), 32'd300);
        chk("sat_count",    32'(clip_count), 32'd255);
        chk("sat_plots",    32'(plots), 32'd0);

        // Reset with three pixels buffered.
        set_src(0, 8'd1, 7'd1, 9'h001);
        set_src(1, 8'd2, 7'd2, 9'h002);
        set_src(2, 8'd3, 7'd3, 9'h003);
        src_valid = 4'b0111;
        tick();
        src_valid = '0;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_plot",  32'(vga_plot), 32'd0);
        chk("mid_rst_x",     32'(vga_x), 32'd0);
        chk("mid_rst_clip",  32'(clip_count), 32'd0);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(src_ready), 32'hF);
        tick();
        tick();
        #2;
        reset = 1'b0;
        plots = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (vga_plot) plots++;
        end
        chk("post_rst_no_plot", 32'(plots), 32'd0);
        set_src(0, 8'd12, 7'd34, 9'h055);
        set_src(2, 8'd13, 7'd35, 9'h0AA);
        src_valid = 4'b0101;
        tick();
        src_valid = '0;
        chk("post_rst_lat1", 32'(vga_plot), 32'd0);
        tick();
        chk("post_rst_plot",   32'(vga_plot), 32'd1);
        chk("post_rst_grant",  32'(vga_grant_src), 32'd0);
        chk("post_rst_x",      32'(vga_x), 32'd12);
        chk("post_rst_colour", 32'(vga_colour), 32'h055);
        tick();
        chk("post_rst_plot2",  32'(vga_plot), 32'd1);
        chk("post_rst_grant2", 32'(vga_grant_src), 32'd2);
        chk("post_rst_x2",     32'(vga_x), 32'd13);
        tick();
        tick();
        chk("post_rst_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
